decode_ctrl: RTL and testbench

- Combined RV32I instruction decoder and main control unit for the single-issue core.
- Sits between fetch and register-file/ALU.
- Splits the fetched instruction into register indices, funct fields, shift amount and a sign-extended immediate.
- Derives datapath control strobes (PC select, operand selects, ALU op, memory enables, writeback select) from the decoded fields.

---
 rtl/decode_ctrl_pkg.sv | 64 ++++++
 rtl/decode_ctrl_if.sv | 25 ++
 rtl/decode_ctrl_imm_gen.sv | 23 ++
 rtl/decode_ctrl.sv | 107 ++++++++++
 tb/tb_decode_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: opcodes, writeback/ALU encodings, instruction formats and
// the shared decode helpers used by decode_ctrl and its immediate generator.
package decode_ctrl_pkg;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [31:0] INSN_NOP = 32'h00000013;
   typedef enum logic [1:0] {WBSEL_ALU, WBSEL_MEM, WBSEL_PC4, WBSEL_IMM} wbsel_e;
   typedef enum logic [3:0] {
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
      ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND, ALU_OP_COPY_B
   } alu_op_e;
   typedef enum logic [2:0] {FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] shamt;
   } fields_t;
   typedef struct packed {
      logic    pcsel;
      logic    immsel;
      logic    regwren;
      logic    rs1sel;
      logic    rs2sel;
      logic    memren;
      logic    memwren;
      wbsel_e  wbsel;
      alu_op_e alusel;
   } ctrl_t;
   function automatic fmt_e fmt_of(input logic [6:0] op);
      case (op)
         OPCODE_OP:                              return FMT_R;
         OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: return FMT_I;
         OPCODE_STORE:                           return FMT_S;
         OPCODE_BRANCH:                          return FMT_B;
         OPCODE_LUI, OPCODE_AUIPC:               return FMT_U;
         OPCODE_JAL:                             return FMT_J;
         default:                                return FMT_X;
      endcase
   endfunction
   // alt is insn[30]; SUB is only legal for register-register ops
   function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt, input logic sub_en);
      case (f3)
         3'b000:  return (alt && sub_en) ? ALU_OP_SUB : ALU_OP_ADD;
         3'b001:  return ALU_OP_SLL;
         3'b010:  return ALU_OP_SLT;
         3'b011:  return ALU_OP_SLTU;
         3'b100:  return ALU_OP_XOR;
         3'b101:  return alt ? ALU_OP_SRA : ALU_OP_SRL;
         3'b110:  return ALU_OP_OR;
         default: return ALU_OP_AND;
      endcase
   endfunction
endpackage

// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetched instruction/PC toward the decoder and decoded
// fields plus control strobes back toward the register file and ALU.
interface decode_ctrl_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic [DWIDTH-1:0] insn_i, insn_o, imm_o;
   logic [AWIDTH-1:0] pc_i, pc_o;
   logic [6:0] opcode_o, funct7_o;
   logic [4:0] rd_o, rs1_o, rs2_o, shamt_o;
   logic [2:0] funct3_o;
   logic pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o;
   logic [1:0] wbsel_o;
   logic [3:0] alusel_o;
   modport master (
      output insn_i, pc_i,
      input  pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o, imm_o,
      input  pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, wbsel_o, alusel_o
   );
   modport slave (
      input  insn_i, pc_i,
      output pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o, imm_o,
      output pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, wbsel_o, alusel_o
   );
endinterface

// File: rtl/decode_ctrl_imm_gen.sv
// decode_ctrl_imm_gen: format-based sign-extended immediate and shamt extraction.
module decode_ctrl_imm_gen import decode_ctrl_pkg::*; #(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:7] insn_i,
   input  fmt_e              fmt_i,
   output logic [DWIDTH-1:0] imm_o,
   output logic [4:0]        shamt_o
);
   always_comb begin
      imm_o = '0;
      case (fmt_i)
         FMT_I:   imm_o = DWIDTH'($signed(insn_i[31:20]));
         FMT_S:   imm_o = DWIDTH'($signed({insn_i[31:25], insn_i[11:7]}));
         FMT_B:   imm_o = DWIDTH'($signed({insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0}));
         FMT_U:   imm_o = DWIDTH'($signed({insn_i[31:12], 12'b0}));
         FMT_J:   imm_o = DWIDTH'($signed({insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0}));
         default: imm_o = '0;
      endcase
      shamt_o = (fmt_i == FMT_R || fmt_i == FMT_I) ? insn_i[24:20] :
                (fmt_i == FMT_S) ? insn_i[11:7] : '0;
   end
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: RV32I instruction decoder and main control unit.
// Define DECODE_REG_OUT_EN to register every output (1-cycle latency, async active-low rst).
module decode_ctrl import decode_ctrl_pkg::*; #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   decode_ctrl_if.slave bus
);
   logic [DWIDTH-1:0] insn_d, imm_d, insn_s, imm_s;
   logic [AWIDTH-1:0] pc_d, pc_s;
   logic [4:0] shamt;
   fmt_e fmt;
   fields_t fld_d, fld_s;
   ctrl_t ctrl_d, ctrl_s;
   assign insn_d = bus.insn_i;
   assign pc_d = bus.pc_i;
   assign fmt = fmt_of(insn_d[6:0]);
   decode_ctrl_imm_gen #(.DWIDTH(DWIDTH)) u_imm_gen (
      .insn_i(insn_d[DWIDTH-1:7]),
      .fmt_i(fmt),
      .imm_o(imm_d),
      .shamt_o(shamt)
   );
   always_comb begin
      fld_d = '0;
      fld_d.opcode = insn_d[6:0];
      fld_d.shamt = shamt;
      fld_d.rd = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? insn_d[11:7] : '0;
      fld_d.rs1 = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? insn_d[19:15] : '0;
      fld_d.rs2 = (fmt inside {FMT_R, FMT_S, FMT_B}) ? insn_d[24:20] : '0;
      fld_d.funct3 = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? insn_d[14:12] : '0;
      // immediate shifts carry the SRA/SRL selector in funct7
      fld_d.funct7 = (fmt == FMT_R || (insn_d[6:0] == OPCODE_OP_IMM && insn_d[13:12] == 2'b01)) ?
                     insn_d[31:25] : '0;
   end
   // strobe order: pcsel immsel regwren rs1sel rs2sel memren memwren
   always_comb begin
      ctrl_d = '0;
      case (insn_d[6:0])
         OPCODE_LUI:    ctrl_d = {7'b0110000, WBSEL_IMM, ALU_OP_COPY_B};
         OPCODE_AUIPC:  ctrl_d = {7'b0111000, WBSEL_ALU, ALU_OP_ADD};
         OPCODE_OP_IMM: ctrl_d = {7'b0110000, WBSEL_ALU, alu_of(insn_d[14:12], insn_d[30], 1'b0)};
         OPCODE_OP:     ctrl_d = {7'b0010100, WBSEL_ALU, alu_of(insn_d[14:12], insn_d[30], 1'b1)};
         OPCODE_LOAD:   ctrl_d = {7'b0110010, WBSEL_MEM, ALU_OP_ADD};
         OPCODE_STORE:  ctrl_d = {7'b0100101, WBSEL_ALU, ALU_OP_ADD};
         OPCODE_BRANCH: ctrl_d = {7'b0101100, WBSEL_ALU, ALU_OP_ADD};
         OPCODE_JAL:    ctrl_d = {7'b1111000, WBSEL_PC4, ALU_OP_ADD};
         OPCODE_JALR:   ctrl_d = {7'b1110000, WBSEL_PC4, ALU_OP_ADD};
         default:       ctrl_d = '0;
      endcase
   end
`ifdef DECODE_REG_OUT_EN
   logic [DWIDTH-1:0] insn_q, imm_q;
   logic [AWIDTH-1:0] pc_q;
   fields_t fld_q;
   ctrl_t ctrl_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         insn_q <= DWIDTH'(INSN_NOP);
         imm_q <= '0;
         pc_q <= '0;
         fld_q <= '0;
         ctrl_q <= '0;
      end else begin
         insn_q <= insn_d;
         imm_q <= imm_d;
         pc_q <= pc_d;
         fld_q <= fld_d;
         ctrl_q <= ctrl_d;
      end
   end
   assign insn_s = insn_q;
   assign imm_s = imm_q;
   assign pc_s = pc_q;
   assign fld_s = fld_q;
   assign ctrl_s = ctrl_q;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign insn_s = insn_d;
   assign imm_s = imm_d;
   assign pc_s = pc_d;
   assign fld_s = fld_d;
   assign ctrl_s = ctrl_d;
`endif
   assign bus.pc_o = pc_s;
   assign bus.insn_o = insn_s;
   assign bus.imm_o = imm_s;
   assign bus.opcode_o = fld_s.opcode;
   assign bus.rd_o = fld_s.rd;
   assign bus.rs1_o = fld_s.rs1;
   assign bus.rs2_o = fld_s.rs2;
   assign bus.funct3_o = fld_s.funct3;
   assign bus.funct7_o = fld_s.funct7;
   assign bus.shamt_o = fld_s.shamt;
   assign bus.pcsel_o = ctrl_s.pcsel;
   assign bus.immsel_o = ctrl_s.immsel;
   assign bus.regwren_o = ctrl_s.regwren;
   assign bus.rs1sel_o = ctrl_s.rs1sel;
   assign bus.rs2sel_o = ctrl_s.rs2sel;
   assign bus.memren_o = ctrl_s.memren;
   assign bus.memwren_o = ctrl_s.memwren;
   assign bus.wbsel_o = ctrl_s.wbsel;
   assign bus.alusel_o = ctrl_s.alusel;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed and randomized checks of decode_ctrl against a
// field-rule reference model; handles both the combinational and registered builds.
module tb_decode_ctrl;
   logic clk = 1'b0;
   logic rst;
   int n_assert = 0;
   int n_fail = 0;
   logic [31:0] cur_insn, cur_pc;
   always #5 clk = ~clk;
   decode_ctrl_if #(.DWIDTH(32), .AWIDTH(32)) bus ();
   decode_ctrl #(.DWIDTH(32), .AWIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  sh;
      logic [31:0] imm;
      logic [12:0] ctl;
   } exp_t;
   function automatic exp_t model(input logic [31:0] i);
      exp_t e;
      byte f;
      logic [3:0] alu;
      int sgn;
      int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      e = '0;
      e.op = i[6:0];
      alu = 4'(alu_tab[i[14:12]]);
      if (i[14:12] == 3'd5 && i[30]) alu = 4'd7;
      if (i[14:12] == 3'd0 && i[30] && i[6:0] == 7'h33) alu = 4'd1;
      f = "X";
      case (i[6:0])
         7'h37: begin f = "U"; e.ctl = {7'b0110000, 2'd3, 4'd10}; end
         7'h17: begin f = "U"; e.ctl = {7'b0111000, 2'd0, 4'd0}; end
         7'h13: begin f = "I"; e.ctl = {7'b0110000, 2'd0, alu}; end
         7'h33: begin f = "R"; e.ctl = {7'b0010100, 2'd0, alu}; end
         7'h03: begin f = "I"; e.ctl = {7'b0110010, 2'd1, 4'd0}; end
         7'h23: begin f = "S"; e.ctl = {7'b0100101, 2'd0, 4'd0}; end
         7'h63: begin f = "B"; e.ctl = {7'b0101100, 2'd0, 4'd0}; end
         7'h6F: begin f = "J"; e.ctl = {7'b1111000, 2'd2, 4'd0}; end
         7'h67: begin f = "I"; e.ctl = {7'b1110000, 2'd2, 4'd0}; end
         default: f = "X";
      endcase
      if (f == "R" || f == "I" || f == "U" || f == "J") e.rd = i[11:7];
      if (f == "R" || f == "I" || f == "S" || f == "B") begin
         e.rs1 = i[19:15];
         e.f3 = i[14:12];
      end
      if (f == "R" || f == "S" || f == "B") e.rs2 = i[24:20];
      if (f == "R" || (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))) e.f7 = i[31:25];
      if (f == "R" || f == "I") e.sh = i[24:20];
      if (f == "S") e.sh = i[11:7];
      sgn = i[31] ? 1 : 0;
      case (f)
         "I": e.imm = 32'(int'(i[31:20]) - sgn * 4096);
         "S": e.imm = 32'(int'(i[31:25]) * 32 + int'(i[11:7]) - sgn * 4096);
         "B": e.imm = 32'(int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - sgn * 4096);
         "U": e.imm = i & 32'hFFFF_F000;
         "J": e.imm = 32'(int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - sgn * 1048576);
         default: e.imm = '0;
      endcase
      return e;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask
   function automatic logic [12:0] obs_ctl();
      return {bus.pcsel_o, bus.immsel_o, bus.regwren_o, bus.rs1sel_o, bus.rs2sel_o,
              bus.memren_o, bus.memwren_o, bus.wbsel_o, bus.alusel_o};
   endfunction
   task automatic check_model(input string tag);
      exp_t e;
      e = model(cur_insn);
      chk({tag, ".pc"}, bus.pc_o, cur_pc);
      chk({tag, ".insn"}, bus.insn_o, cur_insn);
      chk({tag, ".opcode"}, 32'(bus.opcode_o), 32'(e.op));
      chk({tag, ".rd"}, 32'(bus.rd_o), 32'(e.rd));
      chk({tag, ".rs1"}, 32'(bus.rs1_o), 32'(e.rs1));
      chk({tag, ".rs2"}, 32'(bus.rs2_o), 32'(e.rs2));
      chk({tag, ".funct3"}, 32'(bus.funct3_o), 32'(e.f3));
      chk({tag, ".funct7"}, 32'(bus.funct7_o), 32'(e.f7));
      chk({tag, ".shamt"}, 32'(bus.shamt_o), 32'(e.sh));
      chk({tag, ".imm"}, bus.imm_o, e.imm);
      chk({tag, ".ctl"}, 32'(obs_ctl()), 32'(e.ctl));
   endtask
   task automatic check_nop(input string tag);
      chk({tag, ".insn"}, bus.insn_o, 32'h00000013);
      chk({tag, ".pc"}, bus.pc_o, 32'h0);
      chk({tag, ".fields"}, 32'({bus.opcode_o, bus.rd_o, bus.rs1_o, bus.rs2_o, bus.funct3_o}), 32'h0);
      chk({tag, ".f7sh"}, 32'({bus.funct7_o, bus.shamt_o}), 32'h0);
      chk({tag, ".imm"}, bus.imm_o, 32'h0);
      chk({tag, ".ctl"}, 32'(obs_ctl()), 32'h0);
   endtask
   task automatic apply(input logic [31:0] insn, input logic [31:0] pc);
      @(negedge clk);
      bus.insn_i = insn;
      bus.pc_i = pc;
      cur_insn = insn;
      cur_pc = pc;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h00};
      logic [31:0] r, r2;
      logic [6:0] op;
      rst = 1'b0;
      bus.insn_i = 32'h123452B7;
      bus.pc_i = 32'h0000_0100;
      cur_insn = 32'h123452B7;
      cur_pc = 32'h0000_0100;
      #12;
`ifdef DECODE_REG_OUT_EN
      check_nop("reset");
`else
      check_model("reset_comb");
`endif
      @(negedge clk);
      rst = 1'b1;
      apply(32'h123452B7, 32'h0000_1000);
      check_model("lui");
      chk("lui.imm", bus.imm_o, 32'h12345000);
      chk("lui.rd", 32'(bus.rd_o), 5);
      chk("lui.wbsel", 32'(bus.wbsel_o), 3);
      chk("lui.alusel", 32'(bus.alusel_o), 10);
      apply(32'hFFC48413, 32'h0000_1004);
      check_model("addi");
      chk("addi.imm", bus.imm_o, 32'hFFFFFFFC);
      chk("addi.shamt", 32'(bus.shamt_o), 28);
      chk("addi.rs1", 32'(bus.rs1_o), 9);
      apply(32'h0036D613, 32'h0000_1008);
      check_model("srli");
      chk("srli.imm", bus.imm_o, 32'h3);
      chk("srli.alusel", 32'(bus.alusel_o), 6);
      apply(32'h41078733, 32'h0000_100C);
      check_model("sub");
      chk("sub.funct7", 32'(bus.funct7_o), 32'h20);
      chk("sub.shamt", 32'(bus.shamt_o), 16);
      chk("sub.alusel", 32'(bus.alusel_o), 1);
      chk("sub.immsel", 32'(bus.immsel_o), 0);
      apply(32'h0100A503, 32'h0000_1010);
      check_model("lw");
      chk("lw.imm", bus.imm_o, 32'd16);
      chk("lw.memren", 32'(bus.memren_o), 1);
      chk("lw.wbsel", 32'(bus.wbsel_o), 1);
      apply(32'h00B0AA23, 32'h0000_1014);
      check_model("sw");
      chk("sw.imm", bus.imm_o, 32'd20);
      chk("sw.rs2", 32'(bus.rs2_o), 11);
      chk("sw.shamt", 32'(bus.shamt_o), 20);
      chk("sw.memwren", 32'(bus.memwren_o), 1);
      chk("sw.regwren", 32'(bus.regwren_o), 0);
      #2;
      rst = 1'b0;
      #1;
`ifdef DECODE_REG_OUT_EN
      check_nop("midrst");
`else
      check_model("midrst_comb");
`endif
      @(negedge clk);
      rst = 1'b1;
      bus.insn_i = 32'hFFC48413;
      bus.pc_i = 32'h0000_2000;
      cur_insn = 32'hFFC48413;
      cur_pc = 32'h0000_2000;
      #1;
`ifdef DECODE_REG_OUT_EN
      check_nop("release");
`else
      check_model("release_comb");
`endif
      @(posedge clk);
      #1;
      check_model("addi_after_rst");
      chk("addi_after_rst.imm", bus.imm_o, 32'hFFFFFFFC);
      apply(32'h00418463, 32'h0000_2004);
      check_model("beq");
      chk("beq.imm", bus.imm_o, 32'd8);
      chk("beq.shamt", 32'(bus.shamt_o), 0);
      chk("beq.regwren", 32'(bus.regwren_o), 0);
      chk("beq.immsel", 32'(bus.immsel_o), 1);
      apply(32'h00C100E7, 32'h0000_2008);
      check_model("jalr");
      chk("jalr.imm", bus.imm_o, 32'd12);
      chk("jalr.shamt", 32'(bus.shamt_o), 12);
      chk("jalr.wbsel", 32'(bus.wbsel_o), 2);
      chk("jalr.pcsel", 32'(bus.pcsel_o), 1);
      for (int k = 0; k < 300; k++) begin
         r = $urandom();
         r2 = $urandom();
         op = ops[$urandom_range(0, 11)];
         if (k % 10 == 0) op = r2[6:0];
         apply({r[31:7], op}, r2);
         check_model("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
